// File: rtl/bit_demux_8_if.sv
// Signal bundle for bit_demux_8: write controls, address, mode and the parallel/readback outputs.
// master drives the controls; slave is the demux itself.
interface bit_demux_8_if;
  logic       n_g;
  logic       wr;
  logic       d;
  logic       a;
  logic       b;
  logic       c;
  logic       mode;
  logic [7:0] q;
  logic       y;
  logic       w;
  logic [2:0] cnt;
  logic       done;

  modport master (
    output n_g, wr, d, a, b, c, mode,
    input  q, y, w, cnt, done
  );

  modport slave (
    input  n_g, wr, d, a, b, c, mode,
    output q, y, w, cnt, done
  );
endinterface

// File: rtl/bit_demux_8.sv
// Addressable 8-bit latch with gated readback. Defining BIT_DEMUX_8_SEQ_EN adds a sequential
// fill mode that stages eight serial bits and loads q in one shot.
module bit_demux_8 (
  input logic       clk,
  input logic       rst,
  bit_demux_8_if.slave bus
);

  logic [2:0] sel;
  logic       wr_en;
  logic       y_int;
  logic [7:0] q_q, q_d;

  assign sel   = {bus.c, bus.b, bus.a};
  assign wr_en = ~bus.n_g & bus.wr;

`ifdef BIT_DEMUX_8_SEQ_EN
  logic [7:0] stage_q, stage_d, stage_base;
  logic [2:0] cnt_q, cnt_d, cnt_base;
  logic       done_q, done_d;
  logic       mode_q;
  logic       mode_chg;

  // A mode change discards the partial byte; a write on the same edge starts a fresh one.
  always_comb begin
    mode_chg   = bus.mode != mode_q;
    cnt_base   = mode_chg ? 3'd0 : cnt_q;
    stage_base = mode_chg ? 8'h00 : stage_q;
    q_d        = q_q;
    cnt_d      = cnt_base;
    stage_d    = stage_base;
    done_d     = 1'b0;
    if (wr_en) begin
      if (bus.mode) begin
        stage_d[cnt_base] = bus.d;
        cnt_d             = cnt_base + 3'd1;
        if (cnt_base == 3'd7) begin
          q_d    = {bus.d, stage_base[6:0]};
          done_d = 1'b1;
        end
      end else begin
        q_d[sel] = bus.d;
        cnt_d    = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= 8'h00;
      stage_q <= 8'h00;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      mode_q  <= bus.mode;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  always_comb begin
    q_d = q_q;
    if (wr_en) q_d[sel] = bus.d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  assign bus.cnt  = 3'd0;
  assign bus.done = 1'b0;
`endif

  assign y_int = ~bus.n_g & q_q[sel];
  assign bus.q = q_q;
  assign bus.y = y_int;
  assign bus.w = ~y_int;

endmodule

// File: tb/tb_bit_demux_8.sv
// Self-checking bench for bit_demux_8: vector table, hand-written corner sequences and random
// stimulus against a queue-based reference model (follows BIT_DEMUX_8_SEQ_EN like the DUT).
module tb_bit_demux_8;

`ifdef BIT_DEMUX_8_SEQ_EN
  localparam bit Seq = 1'b1;
`else
  localparam bit Seq = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit_demux_8_if bus ();

  bit_demux_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: q as a byte, the partial sequential byte as a queue of bits.
  logic [7:0] m_q;
  bit         m_stage[$];
  logic       m_last_mode;
  logic       m_done;

  task automatic model_reset();
    m_q = 8'h00;
    m_stage.delete();
    m_last_mode = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input logic ng, input logic wr_, input logic d_,
                            input logic [2:0] ad, input logic md);
    m_done = 1'b0;
    if (Seq && md != m_last_mode) m_stage.delete();
    m_last_mode = md;
    if (!ng && wr_) begin
      if (!Seq || !md) begin
        m_q[ad] = d_;
        m_stage.delete();
      end else begin
        m_stage.push_back(d_);
        if (m_stage.size() == 8) begin
          for (int i = 0; i < 8; i++) m_q[i] = m_stage[i];
          m_stage.delete();
          m_done = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [2:0] m_cnt();
    return Seq ? 3'(m_stage.size()) : 3'd0;
  endfunction

  function automatic logic m_y();
    logic [2:0] ad;
    ad = {bus.c, bus.b, bus.a};
    return bus.n_g ? 1'b0 : m_q[ad];
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    check({nm, ".q"}, bus.q, m_q);
    check({nm, ".cnt"}, {5'd0, bus.cnt}, {5'd0, m_cnt()});
    check({nm, ".done"}, {7'd0, bus.done}, {7'd0, m_done});
    check({nm, ".y"}, {7'd0, bus.y}, {7'd0, m_y()});
    check({nm, ".w"}, {7'd0, bus.w}, {7'd0, ~m_y()});
  endtask

  task automatic drive(input logic ng, input logic wr_, input logic d_,
                       input logic [2:0] ad, input logic md);
    bus.n_g = ng; bus.wr = wr_; bus.d = d_;
    {bus.c, bus.b, bus.a} = ad;
    bus.mode = md;
  endtask

  task automatic step(input string nm, input logic ng, input logic wr_, input logic d_,
                      input logic [2:0] ad, input logic md);
    drive(ng, wr_, d_, ad, md);
    @(posedge clk);
    model_edge(ng, wr_, d_, ad, md);
    #1;
    check_model(nm);
  endtask

  // Reset pulsed between clock edges; effects must be visible without a clock.
  task automatic async_reset(input string nm);
    rst = 1'b1;
    #1;
    model_reset();
    check({nm, ".q"}, bus.q, 8'h00);
    check({nm, ".cnt"}, {5'd0, bus.cnt}, 8'h00);
    check({nm, ".done"}, {7'd0, bus.done}, 8'h00);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic       ng;
    logic       wr;
    logic       d;
    logic [2:0] ad;
    logic [7:0] exp_q;
    logic       exp_y;
    logic       exp_w;
  } vec_t;

  vec_t vecs[10];
  int   done_seen;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    model_reset();
    #2;
    async_reset("reset");
    check_model("reset_idle");

    // Addressed writes and readback, mode 0 (same result in both builds).
    vecs[0] = '{1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd2, 8'h05, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 3'd5, 8'h25, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'd7, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd7, 8'hA5, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd7, 8'hA5, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 3'd7, 8'hA5, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'hA1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 3'd2, 8'hA5, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step("vec", vecs[i].ng, vecs[i].wr, vecs[i].d, vecs[i].ad, 1'b0);
      check("vec.q_tbl", bus.q, vecs[i].exp_q);
      check("vec.y_tbl", {7'd0, bus.y}, {7'd0, vecs[i].exp_y});
      check("vec.w_tbl", {7'd0, bus.w}, {7'd0, vecs[i].exp_w});
    end

    // Clear q, then a full sequential byte 1,0,1,0,0,1,0,1.
    for (int i = 0; i < 8; i++) step("clr", 1'b0, 1'b1, 1'b0, 3'(i), 1'b0);
    for (int i = 0; i < 8; i++) step("seq", 1'b0, 1'b1, 1'((8'hA5 >> i) & 1), 3'd3, 1'b1);
    step("seq_after", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Abort by mode change, then a byte of ones: exactly one done pulse.
    done_seen = 0;
    for (int i = 0; i < 3; i++) step("abort3", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    step("mode0", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("ff", 1'b0, (i < 8), 1'b1, 3'd4, 1'b1);
      done_seen += int'(bus.done);
    end
    check("ff_done_count", 8'(done_seen), Seq ? 8'd1 : 8'd0);

    // Abort by reset at cnt=4, then a full byte.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    async_reset("mid_rst");
    for (int i = 0; i < 9; i++) step("post_rst", 1'b0, (i < 8), 1'(i & 1), 3'd6, 1'b1);

    // Write gating.
    for (int i = 0; i < 3; i++) step("part", 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) step("gate_ng", 1'b1, 1'b1, 1'b0, 3'(i), 1'b1);
    for (int i = 0; i < 10; i++) step("gate_wr", 1'b0, 1'b0, 1'b0, 3'(i), 1'b1);

    // Randomized traffic with occasional mode flips and reset pulses.
    begin
      logic md;
      md = 1'b1;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 9) == 0) md = ~md;
        step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom), 3'($urandom), md);
        if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_demux_8.md
BIT_DEMUX_8 -- requirements
Module: bit_demux_8

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port n_g, input, 1 bit: active-low enable for writes and readback.
REQ-004 The block SHALL have the port wr, input, 1 bit: write strobe, sampled on clk.
REQ-005 The block SHALL have the port d, input, 1 bit: serial data bit.
REQ-006 The block SHALL have the ports a, b, c, inputs, 1 bit each: bit address {c,b,a}, with a as LSB.
REQ-007 The block SHALL have the port mode, input, 1 bit: 0 = addressed write, 1 = sequential fill.
REQ-008 The block SHALL have the port q, output, 8 bits: the parallel output register.
REQ-009 The block SHALL have the ports y and w, outputs, 1 bit each: readback of q[{c,b,a}] and its complement.
REQ-010 The block SHALL have the port cnt, output, 3 bits: sequential fill position.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle pulse when a sequential byte completes.

Function
REQ-012 A write SHALL occur on a rising clk edge only when n_g=0 and wr=1; otherwise q, the staging register and cnt hold.
REQ-013 In addressed mode (mode=0), a write SHALL set q[{c,b,a}] <= d, leave the other seven q bits unchanged, and set cnt <= 0.
REQ-014 In sequential mode (mode=1), a write SHALL store d into staging bit cnt and advance cnt by 1, modulo 8; a, b and c are ignored for writes.
REQ-015 A sequential write with cnt=7 SHALL load q <= {d, staging[6:0]} on the same edge, wrap cnt to 0, and assert done for exactly the following cycle.
REQ-016 Before q is loaded (REQ-015), q SHALL keep its previous value during a sequential fill.
REQ-017 done SHALL be 0 in every cycle other than the one defined in REQ-015; back-to-back bytes SHALL give one done pulse per 8 writes.
REQ-018 When the sampled mode differs from the mode sampled on the previous edge, the block SHALL clear cnt and staging on that edge; the byte in progress is discarded and q is unchanged.
REQ-019 When n_g=1, y SHALL be 0 and w SHALL be 1.
REQ-020 When n_g=0, y SHALL equal q[{c,b,a}] combinationally and w SHALL equal ~y.
REQ-021 y SHALL reflect a write at a selected bit immediately after the clk edge that performs it.

Reset
REQ-022 While rst=1, q SHALL be 8'h00, staging 8'h00, cnt 0 and done 0, regardless of clk.
REQ-023 An assertion of rst during a sequential fill SHALL discard the partial byte.
REQ-024 The first write after rst deasserts SHALL be taken on the first rising clk edge at which n_g=0 and wr=1.

Configuration
REQ-025 With macro BIT_DEMUX_8_SEQ_EN defined, the block SHALL implement sequential mode as specified above.
REQ-026 Without BIT_DEMUX_8_SEQ_EN, the mode input SHALL be ignored and all writes SHALL behave as addressed writes.
REQ-027 Without BIT_DEMUX_8_SEQ_EN, cnt SHALL be tied to 0, done SHALL be tied to 0, and no staging register SHALL exist.

Verification
REQ-028 Reset/disable: rst=1 then rst=0 with n_g=1 and address 0 -> q=8'h00, y=0, w=1, cnt=0, done=0.
REQ-029 Addressed writes: mode=0, n_g=0, wr=1, write d=1 at addresses 0, 2, 5, 7 -> q=8'b10100101; address 1 reads y=0, w=1; address 7 reads y=1, w=0.
REQ-030 Sequential byte: mode=1, 8 writes of d = 1,0,1,0,0,1,0,1 (cnt 0..7) -> q stays at its previous value through write 7, then q=8'b10100101; done=1 for one cycle; cnt=0.
REQ-031 Abort by mode change: 3 sequential writes, then mode=0 for one edge, then 8 sequential writes of 8'hFF -> q=8'hFF; exactly one done pulse.
REQ-032 Abort by reset: rst pulsed asynchronously between clk edges at cnt=4 -> q=8'h00 and cnt=0 immediately; the next 8 writes produce a full byte.
REQ-033 Write gating: wr=1 with n_g=1 for 10 edges, and n_g=0 with wr=0 for 10 edges -> q, cnt and done unchanged.
